// File: rtl/clock_gearbox.sv
// clock_gearbox
//   Clock divider and reset generator that sits between the board pins and
//   the SOC core.
//   - Divides the board clock CLK by 2^SLOW to make the slow core clock clk.
//   - Turns the synchronous active-high RESET button into the active-low core
//     reset resetn. resetn is stretched by RESET_HOLD slow periods and is
//     released only on a slow-clock falling edge.
//   - Comes out of power-up in reset without any RESET press.
//
// Parameters
//   SLOW        log2 of the division ratio (0 = clk is CLK passed through)
//   RESET_HOLD  extra slow-clock periods resetn stays low after RESET drops
//
// Ports
//   CLK     in   board clock, the only clock in this block
//   RESET   in   reset button, synchronous to CLK, active-high
//   clk     out  divided core clock, 50% duty
//   resetn  out  core reset, active-low, registered on CLK
module clock_gearbox #(
  parameter int SLOW       = 19,
  parameter int RESET_HOLD = 2
) (
  input  logic CLK,
  input  logic RESET,
  output logic clk,
  output logic resetn
);

  localparam int DW = (SLOW < 1) ? 1 : SLOW;
  localparam int HW = (RESET_HOLD < 1) ? 1 : $clog2(RESET_HOLD + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(RESET_HOLD);

  // Registers carry power-up values so clk and resetn are never X and the
  // core sees a reset without anyone pressing the button.
  logic [DW-1:0] d        = '0;
  logic [HW-1:0] h        = HOLD_INIT;
  logic          resetn_q = 1'b0;
  logic          tick;

  // Free-running divider. It deliberately ignores RESET so the core keeps
  // getting clock edges while its reset is asserted.
  always_ff @(posedge CLK) begin
    if (SLOW == 0) d <= '0;
    else           d <= d + DW'(1);
  end

  generate
    if (SLOW == 0) begin : g_pass
      assign clk  = CLK;
      assign tick = 1'b1;
    end else begin : g_div
      // Straight from a register bit: glitch-free. The edge that sees the
      // counter at all-ones wraps it to 0, which is the clk falling edge.
      assign clk  = d[SLOW-1];
      assign tick = (d == {DW{1'b1}});
    end
  endgenerate

  // Reset stretcher. RESET wins at any time; otherwise the hold count is
  // consumed one slow period at a time and resetn is released on a tick.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      h        <= HOLD_INIT;
      resetn_q <= 1'b0;
    end else if (tick) begin
      if (h != '0) h        <= h - HW'(1);
      else         resetn_q <= 1'b1;
    end
  end

  assign resetn = resetn_q;

endmodule

// File: tb/tb_clock_gearbox.sv
// tb_clock_gearbox
//   Self-checking bench for clock_gearbox. Three instances share one board
//   clock: (SLOW=2, HOLD=2) for the directed scenarios, (SLOW=0, HOLD=0) for
//   the pass-through case and (SLOW=3, HOLD=1) for a second division ratio.
//   The reference model works from edge numbers: after CLK edge n the slow
//   clock is high when (n mod P) >= P/2, tick edges are multiples of P, and
//   resetn is 1 once HOLD+1 tick edges have passed since the last edge that
//   sampled RESET=1 (edge 0 standing in for power-up).
module tb_clock_gearbox;

  logic big_clk = 1'b0;
  logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
  logic clk_a, clk_b, clk_c;
  logic rn_a, rn_b, rn_c;

  int checks = 0;
  int errors = 0;

  // clock / reset block
  always #5 big_clk = ~big_clk;

  clock_gearbox #(.SLOW(2), .RESET_HOLD(2)) dut_a (
    .CLK(big_clk), .RESET(rst_a), .clk(clk_a), .resetn(rn_a));
  clock_gearbox #(.SLOW(0), .RESET_HOLD(0)) dut_b (
    .CLK(big_clk), .RESET(rst_b), .clk(clk_b), .resetn(rn_b));
  clock_gearbox #(.SLOW(3), .RESET_HOLD(1)) dut_c (
    .CLK(big_clk), .RESET(rst_c), .clk(clk_c), .resetn(rn_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  // reference model
  int n = 0;                       // CLK rising edges seen so far
  int last_a = 0, last_b = 0, last_c = 0;

  function automatic logic exp_clk(input int edge_n, input int p);
    return (edge_n % p) >= (p / 2);
  endfunction

  function automatic logic exp_rn(input int edge_n, input int last, input int p, input int hold);
    return ((edge_n / p) - (last / p)) >= (hold + 1);
  endfunction

  // driver: one CLK cycle with the reset levels already applied
  task automatic step();
    @(posedge big_clk);
    n++;
    if (rst_a) last_a = n;
    if (rst_b) last_b = n;
    if (rst_c) last_c = n;
    #1;
    check("a_clk",    {31'd0, clk_a}, {31'd0, exp_clk(n, 4)});
    check("a_resetn", {31'd0, rn_a},  {31'd0, exp_rn(n, last_a, 4, 2)});
    check("b_clk_hi", {31'd0, clk_b}, 32'd1);
    check("b_resetn", {31'd0, rn_b},  {31'd0, exp_rn(n, last_b, 1, 0)});
    check("c_clk",    {31'd0, clk_c}, {31'd0, exp_clk(n, 8)});
    check("c_resetn", {31'd0, rn_c},  {31'd0, exp_rn(n, last_c, 8, 1)});
    @(negedge big_clk);
    #1;
    check("b_clk_lo", {31'd0, clk_b}, 32'd0);
  endtask

  initial begin
    // power-up state, before the first edge
    #1;
    check("a_clk_pwr", {31'd0, clk_a}, 32'd0);
    check("a_rn_pwr",  {31'd0, rn_a},  32'd0);
    check("b_rn_pwr",  {31'd0, rn_b},  32'd0);
    check("c_clk_pwr", {31'd0, clk_c}, 32'd0);
    check("c_rn_pwr",  {31'd0, rn_c},  32'd0);

    for (int e = 1; e <= 1500; e++) begin
      // instance a: power-on release, single pulse at 20, re-press mid-hold
      // at 26, a 100-cycle press, then random presses
      if (e < 200) rst_a = (e == 20) || (e == 26) || (e >= 40 && e < 140);
      else         rst_a = ($urandom_range(0, 49) == 0);
      // instance b: a few directed pulses, then frequent random ones
      if (e < 100) rst_b = (e == 10) || (e >= 30 && e < 33);
      else         rst_b = ($urandom_range(0, 4) == 0);
      // instance c: a long press near the start, then random presses
      if (e < 100) rst_c = (e >= 50 && e < 61);
      else         rst_c = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // safety net so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, edge %0d of 1500", n);
    $fatal(1);
  end

endmodule
